// File: rtl/lcd_cmd_sequencer.sv
// Host-side command scheduler for the LCD image controller: queues host opcodes, filters
// illegal ones and issues them one at a time while the controller is idle.
module lcd_cmd_sequencer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ACK_TO = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       host_cmd,
    input  logic             host_push,
    output logic             host_full,
    input  logic             lcd_busy,
    input  logic             lcd_done,
    output logic [3:0]       lcd_cmd,
    output logic             lcd_cmd_valid,
    output logic             seq_idle,
    output logic             seq_done,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(ACK_TO) + 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [3:0]  MAX_OP   = 4'd11;

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    logic [3:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    state_t           state_q, state_d, cmpl_state;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0]       lcd_cmd_q, lcd_cmd_d;
    logic             valid_q, valid_d;
    logic             host_full_q, host_full_d;
    logic             seq_idle_q, seq_idle_d;
    logic             seq_done_q, seq_done_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [7:0]       drop_q, drop_d;
    logic             push_ok, push_drop, pop;

    // host_full is registered, so a push against a full FIFO is dropped even if a pop
    // frees a slot on the same edge; an empty FIFO never bypasses to the issue path.
    always_comb begin
        push_ok   = host_push && !host_full_q && (host_cmd <= MAX_OP);
        push_drop = host_push && !push_ok;
        pop       = (state_q == S_IDLE) && (count_q != '0) && !lcd_busy;
        count_d   = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // A WRITE only closes the session once the controller reports write-back done.
    always_comb begin
        if (lcd_cmd_q != 4'd0) begin
            cmpl_state = S_IDLE;
        end else if (lcd_done) begin
            cmpl_state = S_FINISH;
        end else begin
            cmpl_state = S_WAIT_DONE;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_BOOT: begin
                if (!lcd_busy) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (pop) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (lcd_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TW'(ACK_TO - 1)) begin
                    state_d = cmpl_state;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!lcd_busy) state_d = cmpl_state;
            end
            S_FINISH: begin
                state_d = S_FINISH;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_comb begin
        lcd_cmd_d   = pop ? mem_q[rd_ptr_q] : lcd_cmd_q;
        valid_d     = pop;
        issued_d    = pop ? issued_q + CNT_W'(1) : issued_q;
        drop_d      = (push_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
        seq_done_d  = seq_done_q || (state_d == S_FINISH);
        host_full_d = (count_d == FULL_CNT) || seq_done_d;
        seq_idle_d  = (state_d == S_IDLE) && (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_BOOT;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            lcd_cmd_q   <= '0;
            valid_q     <= 1'b0;
            host_full_q <= 1'b0;
            seq_idle_q  <= 1'b0;
            seq_done_q  <= 1'b0;
            issued_q    <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q    <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q     <= count_d;
            timer_q     <= timer_d;
            lcd_cmd_q   <= lcd_cmd_d;
            valid_q     <= valid_d;
            host_full_q <= host_full_d;
            seq_idle_q  <= seq_idle_d;
            seq_done_q  <= seq_done_d;
            issued_q    <= issued_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem_q[wr_ptr_q] <= host_cmd;
        end
    end

    assign host_full     = host_full_q;
    assign lcd_cmd       = lcd_cmd_q;
    assign lcd_cmd_valid = valid_q;
    assign seq_idle      = seq_idle_q;
    assign seq_done      = seq_done_q;
    assign issued_cnt    = issued_q;
    assign drop_cnt      = drop_q;

endmodule
